// File: rtl/ddr1_arb_pkg.sv
// Shared types and constants for the DDR1 host-port arbiter.
// Holds the default bus widths, the arbiter state encoding, the read data
// returned on a watchdog expiry and a small one-hot helper.
package ddr1_arb_pkg;

  localparam int          ADDR_W_DEF    = 25;
  localparam int          DATA_W_DEF    = 16;
  localparam logic [15:0] TIMEOUT_RDATA = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP
  } arb_state_t;

  // One-hot decode of a requester index (up to 8 requesters).
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'(1) << idx;
  endfunction

endpackage

// File: rtl/ddr1_host_arbiter_if.sv
// Bus bundle between the system masters, the arbiter and the DDR1 controller
// host port. The arbiter uses the slave modport; the environment driving
// requesters and modelling the controller uses the master modport.
interface ddr1_host_arbiter_if
  import ddr1_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
);

  logic [NUM_REQ-1:0]        m_req_valid;
  logic [NUM_REQ-1:0]        m_req_rw;
  logic [NUM_REQ*ADDR_W-1:0] m_req_addr;
  logic [NUM_REQ*DATA_W-1:0] m_req_wdata;
  logic [NUM_REQ-1:0]        m_req_ack;
  logic [NUM_REQ-1:0]        m_resp_valid;
  logic [DATA_W-1:0]         m_resp_rdata;

  logic                      c_req_valid;
  logic                      c_req_rw;
  logic [ADDR_W-1:0]         c_req_addr;
  logic [DATA_W-1:0]         c_req_wdata;
  logic                      c_req_ack;
  logic                      c_resp_valid;
  logic [DATA_W-1:0]         c_resp_rdata;

  modport slave (
    input  m_req_valid, m_req_rw, m_req_addr, m_req_wdata,
    input  c_req_ack, c_resp_valid, c_resp_rdata,
    output m_req_ack, m_resp_valid, m_resp_rdata,
    output c_req_valid, c_req_rw, c_req_addr, c_req_wdata
  );

  modport master (
    output m_req_valid, m_req_rw, m_req_addr, m_req_wdata,
    output c_req_ack, c_resp_valid, c_resp_rdata,
    input  m_req_ack, m_resp_valid, m_resp_rdata,
    input  c_req_valid, c_req_rw, c_req_addr, c_req_wdata
  );

endinterface

// File: rtl/ddr1_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit found
// searching cyclically from i_ptr+1. The pointer register lives in the parent.
module ddr1_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [2:0]         i_ptr,
  output logic [2:0]         o_idx,
  output logic               o_found
);

  logic [7:0] w_reqExt;
  logic [2:0] w_cand;

  // Walk the candidates in priority order and keep the first hit.
  always_comb begin
    w_reqExt = 8'(i_req);
    w_cand   = '0;
    o_idx    = '0;
    o_found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = 3'((int'(i_ptr) + k) % NUM_REQ);
      if (!o_found && w_reqExt[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/ddr1_host_arbiter.sv
// Round-robin arbiter sharing the DDR1 controller host port between NUM_REQ
// requesters. One transaction is in flight at a time; read data is routed
// back to the requester that issued the read.
// Optional feature macro: DDR1_ARB_TIMEOUT_EN enables a read-response
// watchdog that answers with TIMEOUT_RDATA after TIMEOUT_CYCLES in WAIT_RESP.
module ddr1_host_arbiter
  import ddr1_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  ddr1_host_arbiter_if.slave  bus,
  output logic                busy,
  output logic [2:0]          grant_id,
  output logic                err_spurious,
  output logic                err_timeout
);

  arb_state_t         r_state;
  logic [2:0]         r_ptr;
  logic [2:0]         r_grant;
  logic               r_busy;
  logic               r_errSpurious;
  logic               r_cReqValid;
  logic               r_cReqRw;
  logic [ADDR_W-1:0]  r_cReqAddr;
  logic [DATA_W-1:0]  r_cReqWdata;
  logic [NUM_REQ-1:0] r_mReqAck;
  logic [NUM_REQ-1:0] r_mRespValid;
  logic [DATA_W-1:0]  r_mRespRdata;

  logic [2:0]         w_pickIdx;
  logic               w_pickFound;

`ifdef DDR1_ARB_TIMEOUT_EN
  logic [31:0]        r_wdog;
  logic               r_errTimeout;
`endif

  ddr1_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req   (bus.m_req_valid),
    .i_ptr   (r_ptr),
    .o_idx   (w_pickIdx),
    .o_found (w_pickFound)
  );

  // Arbiter FSM: grant, hold the request until the controller accepts it,
  // then wait for read data if the request was a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ptr         <= 3'(NUM_REQ - 1);
      r_grant       <= '0;
      r_busy        <= 1'b0;
      r_errSpurious <= 1'b0;
      r_cReqValid   <= 1'b0;
      r_cReqRw      <= 1'b0;
      r_cReqAddr    <= '0;
      r_cReqWdata   <= '0;
      r_mReqAck     <= '0;
      r_mRespValid  <= '0;
      r_mRespRdata  <= '0;
`ifdef DDR1_ARB_TIMEOUT_EN
      r_wdog        <= '0;
      r_errTimeout  <= 1'b0;
`endif
    end else begin
      r_mReqAck    <= '0;
      r_mRespValid <= '0;
      if (bus.c_resp_valid && (r_state != WAIT_RESP)) begin
        r_errSpurious <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_pickFound) begin
            r_cReqValid <= 1'b1;
            r_cReqRw    <= bus.m_req_rw[w_pickIdx];
            r_cReqAddr  <= bus.m_req_addr[int'(w_pickIdx)*ADDR_W +: ADDR_W];
            r_cReqWdata <= bus.m_req_wdata[int'(w_pickIdx)*DATA_W +: DATA_W];
            r_grant     <= w_pickIdx;
            r_ptr       <= w_pickIdx;
            r_busy      <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.c_req_ack) begin
            r_cReqValid <= 1'b0;
            r_mReqAck   <= NUM_REQ'(onehot8(r_grant));
            if (r_cReqRw) begin
              r_state <= WAIT_RESP;
`ifdef DDR1_ARB_TIMEOUT_EN
              r_wdog  <= '0;
`endif
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        WAIT_RESP: begin
          if (bus.c_resp_valid) begin
            r_mRespRdata <= bus.c_resp_rdata;
            r_mRespValid <= NUM_REQ'(onehot8(r_grant));
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
`ifdef DDR1_ARB_TIMEOUT_EN
          else if (r_wdog == 32'(TIMEOUT_CYCLES - 1)) begin
            r_mRespRdata <= DATA_W'(TIMEOUT_RDATA);
            r_mRespValid <= NUM_REQ'(onehot8(r_grant));
            r_errTimeout <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end else begin
            r_wdog <= r_wdog + 32'd1;
          end
`endif
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.c_req_valid  = r_cReqValid;
  assign bus.c_req_rw     = r_cReqRw;
  assign bus.c_req_addr   = r_cReqAddr;
  assign bus.c_req_wdata  = r_cReqWdata;
  assign bus.m_req_ack    = r_mReqAck;
  assign bus.m_resp_valid = r_mRespValid;
  assign bus.m_resp_rdata = r_mRespRdata;
  assign busy             = r_busy;
  assign grant_id         = r_grant;
  assign err_spurious     = r_errSpurious;
`ifdef DDR1_ARB_TIMEOUT_EN
  assign err_timeout      = r_errTimeout;
`else
  assign err_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_ddr1_host_arbiter.sv
// Directed self-checking bench for ddr1_host_arbiter: single write, read
// routing, round-robin fairness, spurious responses, reset mid-read and,
// when DDR1_ARB_TIMEOUT_EN is defined, the read watchdog.
module tb_ddr1_host_arbiter;

  localparam int NUM_REQ        = 4;
  localparam int ADDR_W         = 25;
  localparam int DATA_W         = 16;
  localparam int TIMEOUT_CYCLES = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [2:0] grantId;
  logic       errSpurious;
  logic       errTimeout;

  int checkCount = 0;
  int errorCount = 0;

  ddr1_host_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ddr1_host_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .busy         (busy),
    .grant_id     (grantId),
    .err_spurious (errSpurious),
    .err_timeout  (errTimeout)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic valid, input logic rw,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    bus.m_req_valid[idx]                 = valid;
    bus.m_req_rw[idx]                    = rw;
    bus.m_req_addr[idx*ADDR_W +: ADDR_W] = addr;
    bus.m_req_wdata[idx*DATA_W +: DATA_W] = wdata;
  endtask

  task automatic waitReqValid(input string tag);
    int n = 0;
    while (bus.c_req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, "_reqSeen"}, 32'(bus.c_req_valid), 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_cReqValid"},  32'(bus.c_req_valid),  0);
    checkOutput({tag, "_cReqRw"},     32'(bus.c_req_rw),     0);
    checkOutput({tag, "_cReqAddr"},   32'(bus.c_req_addr),   0);
    checkOutput({tag, "_cReqWdata"},  32'(bus.c_req_wdata),  0);
    checkOutput({tag, "_mReqAck"},    32'(bus.m_req_ack),    0);
    checkOutput({tag, "_mRespValid"}, 32'(bus.m_resp_valid), 0);
    checkOutput({tag, "_mRespRdata"}, 32'(bus.m_resp_rdata), 0);
    checkOutput({tag, "_busy"},       32'(busy),             0);
    checkOutput({tag, "_grantId"},    32'(grantId),          0);
    checkOutput({tag, "_errSpur"},    32'(errSpurious),      0);
    checkOutput({tag, "_errTimeout"}, 32'(errTimeout),       0);
  endtask

  // Safety net so the run always ends even if the flow above stalls.
  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] global timeout");
  end

  // Directed stimulus and checks.
  initial begin
    bus.m_req_valid  = '0;
    bus.m_req_rw     = '0;
    bus.m_req_addr   = '0;
    bus.m_req_wdata  = '0;
    bus.c_req_ack    = 1'b0;
    bus.c_resp_valid = 1'b0;
    bus.c_resp_rdata = '0;

    // Reset state.
    rst = 1'b1;
    repeat (3) tick();
    checkAllZero("reset");
    rst = 1'b0;

    // Single write from requester 0.
    applyStimulus(0, 1'b1, 1'b0, 25'h0, 16'hABCD);
    tick();
    checkOutput("wr_cReqValid", 32'(bus.c_req_valid), 1);
    checkOutput("wr_cReqAddr",  32'(bus.c_req_addr),  0);
    checkOutput("wr_cReqWdata", 32'(bus.c_req_wdata), 32'hABCD);
    checkOutput("wr_cReqRw",    32'(bus.c_req_rw),    0);
    checkOutput("wr_grantId",   32'(grantId),         0);
    checkOutput("wr_busy",      32'(busy),            1);
    tick();
    checkOutput("wr_holdValid", 32'(bus.c_req_valid), 1);
    checkOutput("wr_noEarlyAck", 32'(bus.m_req_ack),  0);
    bus.c_req_ack = 1'b1;
    tick();
    checkOutput("wr_mReqAck",   32'(bus.m_req_ack),   32'b0001);
    checkOutput("wr_cReqDrop",  32'(bus.c_req_valid), 0);
    checkOutput("wr_busyIdle",  32'(busy),            0);
    applyStimulus(0, 1'b0, 1'b0, 25'h0, 16'h0);
    bus.c_req_ack = 1'b0;
    tick();
    checkOutput("wr_ackPulse",  32'(bus.m_req_ack),   0);

    // Controller ack while idle is ignored.
    bus.c_req_ack = 1'b1;
    tick();
    bus.c_req_ack = 1'b0;
    checkOutput("idleAck_mReqAck", 32'(bus.m_req_ack), 0);
    checkOutput("idleAck_busy",    32'(busy),          0);

    // Read from requester 2 with the response 12 cycles later.
    applyStimulus(2, 1'b1, 1'b1, 25'h10, 16'h0);
    tick();
    checkOutput("rd_grantId",  32'(grantId),         2);
    checkOutput("rd_cReqRw",   32'(bus.c_req_rw),    1);
    checkOutput("rd_cReqAddr", 32'(bus.c_req_addr),  32'h10);
    bus.c_req_ack = 1'b1;
    tick();
    checkOutput("rd_mReqAck",  32'(bus.m_req_ack),   32'b0100);
    checkOutput("rd_busyWait", 32'(busy),            1);
    applyStimulus(2, 1'b0, 1'b0, 25'h0, 16'h0);
    bus.c_req_ack = 1'b0;
    repeat (11) tick();
    checkOutput("rd_noEarlyResp", 32'(bus.m_resp_valid), 0);
    checkOutput("rd_stillBusy",   32'(busy),             1);
    bus.c_resp_valid = 1'b1;
    bus.c_resp_rdata = 16'h1234;
    tick();
    bus.c_resp_valid = 1'b0;
    checkOutput("rd_mRespValid", 32'(bus.m_resp_valid), 32'b0100);
    checkOutput("rd_mRespRdata", 32'(bus.m_resp_rdata), 32'h1234);
    checkOutput("rd_busyDone",   32'(busy),             0);
    checkOutput("rd_noSpur",     32'(errSpurious),      0);
    tick();
    checkOutput("rd_respPulse",  32'(bus.m_resp_valid), 0);

    // Fairness: reset the pointer, then all four requesters write continuously.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      applyStimulus(i, 1'b1, 1'b0, 25'(i * 16 + 1), 16'(16'h1000 + i));
    end
    for (int g = 0; g < 8; g++) begin
      waitReqValid($sformatf("fair%0d", g));
      checkOutput($sformatf("fair%0d_grant", g), 32'(grantId), 32'(g % 4));
      checkOutput($sformatf("fair%0d_addr", g),  32'(bus.c_req_addr), 32'((g % 4) * 16 + 1));
      bus.c_req_ack = 1'b1;
      tick();
      if (g == 7) bus.m_req_valid = '0;
      checkOutput($sformatf("fair%0d_ack", g), 32'(bus.m_req_ack), 32'(1) << (g % 4));
      bus.c_req_ack = 1'b0;
    end
    tick();
    checkOutput("fair_idle", 32'(busy), 0);

    // Spurious response while idle.
    bus.c_resp_valid = 1'b1;
    bus.c_resp_rdata = 16'h5555;
    tick();
    bus.c_resp_valid = 1'b0;
    checkOutput("spur_err",       32'(errSpurious),      1);
    checkOutput("spur_noResp",    32'(bus.m_resp_valid), 0);
    repeat (3) tick();
    checkOutput("spur_sticky",    32'(errSpurious),      1);

    // Reset during WAIT_RESP.
    applyStimulus(1, 1'b1, 1'b1, 25'h200, 16'h0);
    tick();
    checkOutput("rstMid_grant", 32'(grantId), 1);
    bus.c_req_ack = 1'b1;
    tick();
    applyStimulus(1, 1'b0, 1'b0, 25'h0, 16'h0);
    bus.c_req_ack = 1'b0;
    checkOutput("rstMid_busy", 32'(busy), 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checkAllZero("rstMid");
    rst = 1'b0;
    bus.c_resp_valid = 1'b1;
    bus.c_resp_rdata = 16'h0077;
    tick();
    bus.c_resp_valid = 1'b0;
    checkOutput("lateResp_err",    32'(errSpurious),      1);
    checkOutput("lateResp_noResp", 32'(bus.m_resp_valid), 0);
    applyStimulus(0, 1'b1, 1'b0, 25'h30, 16'h0A0A);
    applyStimulus(2, 1'b1, 1'b0, 25'h40, 16'h0B0B);
    tick();
    checkOutput("postRst_grant", 32'(grantId),        0);
    checkOutput("postRst_addr",  32'(bus.c_req_addr), 32'h30);
    bus.c_req_ack = 1'b1;
    tick();
    checkOutput("postRst_ack",   32'(bus.m_req_ack),  32'b0001);
    applyStimulus(0, 1'b0, 1'b0, 25'h0, 16'h0);
    bus.c_req_ack = 1'b0;
    tick();
    checkOutput("next_grant",    32'(grantId),         2);
    checkOutput("next_wdata",    32'(bus.c_req_wdata), 32'h0B0B);
    bus.c_req_ack = 1'b1;
    tick();
    checkOutput("next_ack",      32'(bus.m_req_ack),   32'b0100);
    applyStimulus(2, 1'b0, 1'b0, 25'h0, 16'h0);
    bus.c_req_ack = 1'b0;
    tick();

`ifdef DDR1_ARB_TIMEOUT_EN
    // Read with no response: watchdog answers after TIMEOUT_CYCLES.
    applyStimulus(3, 1'b1, 1'b1, 25'h50, 16'h0);
    tick();
    checkOutput("to_grant", 32'(grantId), 3);
    bus.c_req_ack = 1'b1;
    tick();
    applyStimulus(3, 1'b0, 1'b0, 25'h0, 16'h0);
    bus.c_req_ack = 1'b0;
    repeat (TIMEOUT_CYCLES - 1) tick();
    checkOutput("to_noEarlyResp", 32'(bus.m_resp_valid), 0);
    checkOutput("to_noEarlyErr",  32'(errTimeout),       0);
    tick();
    checkOutput("to_mRespValid",  32'(bus.m_resp_valid), 32'b1000);
    checkOutput("to_mRespRdata",  32'(bus.m_resp_rdata), 32'hDEAD);
    checkOutput("to_errTimeout",  32'(errTimeout),       1);
    checkOutput("to_busy",        32'(busy),             0);
    tick();
    checkOutput("to_sticky",      32'(errTimeout),       1);
`else
    checkOutput("noTimeout_err", 32'(errTimeout), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/ddr1_host_arbiter.md
Name: ddr1_host_arbiter

Overview:
Shares the single host port of the DDR1 controller (req_valid/req_rw/req_addr/req_wdata/req_ack/resp_valid/resp_rdata) between N requesters using round-robin arbitration.
- Keeps one transaction in flight and routes read data back to the requester that issued the read.
- Sits between the system masters and ddr1_controller. The controller-side port connects 1:1 to the controller host port.

Parameters:
- NUM_REQ, 4, number of requesters (1..8).
- ADDR_W, 25, host address width ({bank, row, col}).
- DATA_W, 16, host data width.
- TIMEOUT_CYCLES, 1024, read-response watchdog limit. Used only with DDR1_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- m_req_valid  in  NUM_REQ  per-requester request valid.
- m_req_rw  in  NUM_REQ  per-requester direction (1 = read, 0 = write).
- m_req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies [i*ADDR_W +: ADDR_W].
- m_req_wdata  in  NUM_REQ*DATA_W  packed write data, packed the same way.
- m_req_ack  out  NUM_REQ  one-hot, single-cycle accept pulse.
- m_resp_valid  out  NUM_REQ  one-hot, single-cycle read-data pulse.
- m_resp_rdata  out  DATA_W  read data shared by all requesters; qualified by m_resp_valid.
- c_req_valid  out  1  to controller req_valid.
- c_req_rw  out  1  to controller req_rw.
- c_req_addr  out  ADDR_W  to controller req_addr.
- c_req_wdata  out  DATA_W  to controller req_wdata.
- c_req_ack  in  1  from controller req_ack.
- c_resp_valid  in  1  from controller resp_valid.
- c_resp_rdata  in  DATA_W  from controller resp_rdata.
- busy  out  1  high whenever the state is not IDLE.
- grant_id  out  3  index of the current or last granted requester.
- err_spurious  out  1  sticky; set when c_resp_valid arrives outside WAIT_RESP.
- err_timeout  out  1  sticky read-timeout flag.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All outputs are 0.
  - State goes to IDLE.
  - The round-robin pointer is set to NUM_REQ-1, so requester 0 wins first.
  - The watchdog counter is 0.
  - A reset during ISSUE or WAIT_RESP abandons the transaction. No ack or response is generated.
- All outputs are registered.
- IDLE:
  - If any m_req_valid is set, grant the first set bit searching cyclically from pointer+1.
  - Latch the granted requester's rw, addr and wdata into c_req_* and set c_req_valid=1.
  - Update grant_id and the pointer, then go to ISSUE.
  - Latency: a requester valid at cycle T with the arbiter idle gives c_req_valid=1 at T+1.
- ISSUE:
  - Hold c_req_valid and all c_req_* fields stable until c_req_ack is sampled high.
  - On that edge: c_req_valid goes to 0, m_req_ack[grant] pulses for one cycle, and the state goes to WAIT_RESP if the request is a read, otherwise IDLE.
- WAIT_RESP:
  - On c_resp_valid: m_resp_rdata takes c_resp_rdata, m_resp_valid[grant] pulses for one cycle, and the state goes to IDLE.
- Back-to-back:
  - After a write ack, the next grant can be made in the following IDLE cycle, so there is a minimum of 1 idle cycle between c_req_valid pulses.
- Requester rules:
  - A requester holds valid and its payload stable until its ack.
  - It drops valid the cycle after the ack, or re-arms it for a new request.
  - A requester that drops valid before its ack is still served once granted, because the payload is already latched.
- Ignored or error inputs:
  - c_req_ack outside ISSUE is ignored.
  - c_resp_valid outside WAIT_RESP is dropped and sets err_spurious.
  - c_resp_valid in the same cycle as c_req_ack in ISSUE is spurious.
- Simultaneous requests: fairness is strict round-robin. With all NUM_REQ requesters valid continuously, each is granted exactly once per NUM_REQ grants.
- NUM_REQ=1: the pointer logic degenerates; requester 0 is always granted.

Optional Feature:
DDR1_ARB_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT_RESP.
  - When it reaches TIMEOUT_CYCLES without c_resp_valid, m_resp_valid[grant] pulses with m_resp_rdata=16'hDEAD, err_timeout sets (sticky), and the state goes to IDLE.
  - A late c_resp_valid after the timeout counts as spurious.
- Undefined:
  - WAIT_RESP waits indefinitely.
  - err_timeout is tied to 0, and the port is kept.

Decomposition:
- Package ddr1_arb_pkg:
  - ADDR_W and DATA_W defaults.
  - State enum {IDLE, ISSUE, WAIT_RESP}.
  - TIMEOUT_RDATA = 16'hDEAD.
- Sub-module ddr1_rr_pick:
  - Combinational round-robin picker.
  - Inputs: request vector and pointer.
  - Outputs: grant index and a grant-found flag.
  - The parent owns the pointer register.

Test Plan:
- Single write: req0 writes addr 0, data 0xABCD.
  - Required: c_req_valid one cycle after m_req_valid, with c_req_addr=0 and c_req_wdata=0xABCD.
  - Required: m_req_ack[0] one cycle after c_req_ack; busy returns to 0.
- Read routing: req2 reads addr 0x10; the controller model returns 0x1234 after 12 cycles.
  - Required: m_resp_valid=4'b0100 with m_resp_rdata=0x1234, and no other m_resp_valid bit set.
- Fairness: all 4 requesters continuously issue writes.
  - Required: grant order 0,1,2,3,0,1,2,3 over 8 grants.
- Spurious response: pulse c_resp_valid while IDLE.
  - Required: err_spurious=1, no m_resp_valid, and err_spurious stays set until rst.
- Reset mid-read: assert rst during WAIT_RESP.
  - Required: all outputs 0 the next cycle and the next grant goes to req0.
  - Required: a later c_resp_valid sets err_spurious.
- Timeout (DDR1_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): issue a read with no response.
  - Required: m_resp_valid pulse with 0xDEAD after 16 WAIT_RESP cycles, and err_timeout=1.
